// File: rtl/bus_slave_if_if.sv
// Shared CPU bus as seen by one responder: the master drives the access, the slave answers.
// The slave returns a one-cycle active-low rdy_ pulse and drives rd_data to 0 outside it.
interface bus_slave_if_if;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_;

    modport master (output cs_, as_, rw, addr, wr_data, input  rd_data, rdy_);
    modport slave  (input  cs_, as_, rw, addr, wr_data, output rd_data, rdy_);
endinterface

// File: rtl/bus_slave_if.sv
// Bus responder: turns a granted bus access into a level req/ack device handshake plus a rdy_ pulse.
// Optional BUS_SLAVE_TIMEOUT_EN adds a DEV-state watchdog with a sticky err flag.
module bus_slave_if #(
    parameter int DEV_ADDR_W = 12,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_slave_if_if.slave         bus,
    output logic                  dev_req_o,
    output logic                  dev_rw_o,
    output logic [DEV_ADDR_W-1:0] dev_addr_o,
    output logic [31:0]           dev_wr_data_o,
    input  logic [31:0]           dev_rd_data_i,
    input  logic                  dev_ack_i,
    output logic                  err_o,
    input  logic                  err_clr_i
);

    typedef enum logic [1:0] {IDLE, DEV, RESP} state_e;

    state_e                state_q, state_d;
    logic                  dev_rw_q, dev_rw_d;
    logic [DEV_ADDR_W-1:0] dev_addr_q, dev_addr_d;
    logic [31:0]           dev_wr_data_q, dev_wr_data_d;
    logic [31:0]           resp_q, resp_d;
    logic                  timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            dev_rw_q      <= 1'b1;
            dev_addr_q    <= '0;
            dev_wr_data_q <= '0;
            resp_q        <= '0;
        end else begin
            state_q       <= state_d;
            dev_rw_q      <= dev_rw_d;
            dev_addr_q    <= dev_addr_d;
            dev_wr_data_q <= dev_wr_data_d;
            resp_q        <= resp_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        dev_rw_d      = dev_rw_q;
        dev_addr_d    = dev_addr_q;
        dev_wr_data_d = dev_wr_data_q;
        resp_d        = resp_q;
        case (state_q)
            IDLE: begin
                if (!bus.as_ && !bus.cs_) begin
                    dev_rw_d      = bus.rw;
                    dev_addr_d    = bus.addr[DEV_ADDR_W-1:0];
                    dev_wr_data_d = bus.wr_data;
                    state_d       = DEV;
                end
            end
            DEV: begin
                // ack on the limit cycle takes priority over the watchdog
                if (dev_ack_i) begin
                    resp_d  = dev_rw_q ? dev_rd_data_i : 32'd0;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    resp_d  = 32'd0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef BUS_SLAVE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    assign timeout_hit = (cnt_q == TO_LAST);

    always_comb begin
        cnt_d = 8'd0;
        err_d = err_clr_i ? 1'b0 : err_q;
        // counter rests at 0 outside DEV so every entry starts fresh
        if (state_q == DEV && !dev_ack_i) begin
            cnt_d = cnt_q + 8'd1;
            if (timeout_hit) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{err_clr_i, bus.addr[29:DEV_ADDR_W], 1'(TIMEOUT)};

    assign dev_req_o     = (state_q == DEV);
    assign dev_rw_o      = dev_rw_q;
    assign dev_addr_o    = dev_addr_q;
    assign dev_wr_data_o = dev_wr_data_q;
    assign bus.rdy_      = (state_q != RESP);
    assign bus.rd_data   = (state_q == RESP) ? resp_q : 32'd0;

endmodule

// File: tb/tb_bus_slave_if.sv
// Randomized bench for bus_slave_if against a per-access latency/data model.
// Honours BUS_SLAVE_TIMEOUT_EN so the same bench covers both builds.
module tb_bus_slave_if;
    localparam int AW = 12;
    localparam int TO = 4;
`ifdef BUS_SLAVE_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          dev_req, dev_rw, dev_ack, err, err_clr, ack_en;
    logic [AW-1:0] dev_addr;
    logic [31:0]   dev_wr_data, dev_rd_data;

    bus_slave_if_if bus();

    bus_slave_if #(.DEV_ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .dev_req_o(dev_req), .dev_rw_o(dev_rw), .dev_addr_o(dev_addr),
        .dev_wr_data_o(dev_wr_data), .dev_rd_data_i(dev_rd_data),
        .dev_ack_i(dev_ack), .err_o(err), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    // device acks combinationally from dev_req in the cycle the bench picks
    assign dev_ack = ack_en & dev_req;

    int total = 0;
    int bad   = 0;

    // model of the latched device-side registers and the sticky error
    logic          m_rw;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wd;
    logic          m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_latched(input string tag);
        chk({tag, ".drw"},   32'(dev_rw),   32'(m_rw));
        chk({tag, ".daddr"}, 32'(dev_addr), 32'(m_addr));
        chk({tag, ".dwd"},   dev_wr_data,   m_wd);
        chk({tag, ".err"},   32'(err),      32'(m_err));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".rdy"}, 32'(bus.rdy_), 32'd1);
        chk({tag, ".rd"},  bus.rd_data,   32'd0);
        chk({tag, ".req"}, 32'(dev_req),  32'd0);
        chk_latched(tag);
    endtask

    task automatic model_reset();
        m_rw = 1'b1; m_addr = '0; m_wd = '0; m_err = 1'b0;
    endtask

    // One access starting at a negedge. Device acks dly cycles after dev_req rises;
    // tail = idle cycles observed after rdy_ (1 lets the next call run back-to-back).
    task automatic access(input logic rw_v, input logic [29:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int dly, input bit extra, input int tail);
        bit timed_out = TO_ON && (dly >= TO);
        int rc        = timed_out ? TO + 1 : dly + 2;
        bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = rw_v; bus.addr = a; bus.wr_data = wd;
        for (int c = 1; c <= rc + tail; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.as_ = 1'b1; bus.cs_ = 1'b1;
                m_rw = rw_v; m_addr = a[AW-1:0]; m_wd = wd;
            end
            if (timed_out && c == rc) m_err = 1'b1;
            chk("acc.req", 32'(dev_req),  32'(c < rc));
            chk("acc.rdy", 32'(bus.rdy_), 32'(c != rc));
            chk("acc.rd",  bus.rd_data,   (c == rc && rw_v && !timed_out) ? rd : 32'd0);
            chk_latched("acc");
            if (extra && c == 2) begin
                bus.as_ = 1'b0; bus.cs_ = 1'b0; bus.addr = ~a; bus.rw = ~rw_v;
            end
            if (extra && c == 3) begin
                bus.as_ = 1'b1; bus.cs_ = 1'b1; bus.addr = a; bus.rw = rw_v;
            end
            ack_en      = (c - 1 == dly);
            dev_rd_data = ack_en ? rd : $urandom();
        end
        ack_en = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = 1'b0;
        chk("errclr", 32'(err), 32'd0);
    endtask

    initial begin
        reset = 1'b1; ack_en = 1'b0; err_clr = 1'b0; dev_rd_data = '0;
        bus.cs_ = 1'b1; bus.as_ = 1'b1; bus.rw = 1'b1; bus.addr = '0; bus.wr_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_idle("rst");
        reset = 1'b0;
        @(negedge clk);
        chk_idle("idle");

        access(1'b1, 30'h0000_0123, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 2);
        access(1'b0, 30'h0000_0456, 32'h1234_5678, 32'hFFFF_FFFF, 3, 1'b0, 2);

        // as_ without cs_ must not start an access
        bus.cs_ = 1'b1; bus.as_ = 1'b0; bus.addr = 30'h3ABC_DEF0; bus.rw = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.as_ = 1'b1;
            chk_idle("nocs");
        end

        access(1'b1, 30'h0000_0777, 32'h5, 32'hCAFE_F00D, 2, 1'b1, 2);
        access(1'b1, 30'h0000_0321, 32'h6, 32'h0BAD_CAFE, TO - 1, 1'b0, 2);
        access(1'b1, 30'h0000_0F0F, 32'h7, 32'h1111_2222, TO + 3, 1'b0, 2);
        clear_err();

        access(1'b1, 30'h0000_0AAA, 32'h8, 32'h3333_4444, 0, 1'b0, 1);
        access(1'b0, 30'h0000_0555, 32'h9, 32'h5555_6666, 0, 1'b0, 1);
        access(1'b1, 30'h0000_0ABC, 32'hA, 32'h7777_8888, 1, 1'b0, 2);

        // no ack: times out with the macro, waits forever without it; then reset mid-access
        bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = 1'b1; bus.addr = 30'h0000_0999; bus.wr_data = 32'hB;
        for (int c = 1; c <= (TO_ON ? 2 : 10); c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.as_ = 1'b1; bus.cs_ = 1'b1;
                m_rw = 1'b1; m_addr = 12'h999; m_wd = 32'hB;
            end
            chk("hang.req", 32'(dev_req),  32'd1);
            chk("hang.rdy", 32'(bus.rdy_), 32'd1);
            chk_latched("hang");
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk_idle("midrst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle("postrst");
        end
        access(1'b1, 30'h0000_0042, 32'h0, 32'h4242_4242, 1, 1'b0, 2);

        for (int n = 0; n < 40; n++) begin
            access(1'($urandom()), 30'($urandom()), $urandom(), $urandom(),
                   int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0),
                   int'($urandom_range(1, 2)));
            if ($urandom_range(0, 2) == 0) clear_err();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
